// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the image loader.
// The loader uses the slave modport; the stream source / memory side uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program image into instruction memory and holds the core
// in reset until done. Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  input  logic         start,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_BYTE   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd6;
  localparam logic [2:0] S_FINAL  = S_CSUM;
`else
  localparam logic [2:0] S_FINAL  = S_DONE;
`endif
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic [15:0]       len_r;
  logic [15:0]       len_s;
  logic [15:0]       index_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [23:0]       word_r;
  logic [1:0]        cnt_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              rx_ready_s;
  logic              accept_s;

  assign accept_s = bus.rx_valid && rx_ready_s;
  assign len_s    = {len_r[15:8], bus.rx_data};

  // Stream ready decoded from state: only header, data and checksum states take bytes.
  always_comb begin
    rx_ready_s = 1'b0;
    case (state_r)
      S_LEN_HI, S_LEN_LO, S_BYTE: rx_ready_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                     rx_ready_s = 1'b1;
`endif
      default:                    rx_ready_s = 1'b0;
    endcase
  end

  // Next-state logic of the load sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: state_s = S_LEN_HI;
      S_LEN_HI: begin
        if (accept_s) state_s = S_LEN_LO;
        else          state_s = state_r;
      end
      S_LEN_LO: begin
        if (!accept_s)          state_s = state_r;
        else if (len_s == 16'd0) state_s = S_FINAL;
        else                    state_s = S_BYTE;
      end
      S_BYTE: begin
        if (accept_s && (cnt_r == 2'd3)) state_s = S_WRITE;
        else                             state_s = state_r;
      end
      S_WRITE: begin
        if (index_r == (len_r - 16'd1)) state_s = S_FINAL;
        else                            state_s = S_BYTE;
      end
      S_DONE: begin
        if (start) state_s = S_LEN_HI;
        else       state_s = state_r;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) state_s = S_DONE;
        else          state_s = state_r;
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_s;
  end

  // Header capture, word assembly and the one-cycle memory write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r       <= 16'd0;
      index_r     <= 16'd0;
      waddr_r     <= {ADDR_W{1'b0}};
      word_r      <= 24'd0;
      cnt_r       <= 2'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'd0;
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        S_LEN_HI: begin
          if (accept_s) len_r[15:8] <= bus.rx_data;
        end
        S_LEN_LO: begin
          if (accept_s) begin
            len_r[7:0] <= bus.rx_data;
            index_r    <= 16'd0;
            waddr_r    <= START_ADDR;
            cnt_r      <= 2'd0;
          end
        end
        S_BYTE: begin
          if (accept_s) begin
            word_r <= {word_r[15:0], bus.rx_data};
            cnt_r  <= cnt_r + 2'd1;
            // Fourth byte completes the word; the write strobe shows up next cycle in S_WRITE.
            if (cnt_r == 2'd3) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= waddr_r;
              mem_wdata_r <= {word_r, bus.rx_data};
            end
          end
        end
        S_WRITE: begin
          index_r <= index_r + 16'd1;
          waddr_r <= waddr_r + ADDR_ONE;
        end
        default: begin
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       load_err_r;

  // Running XOR of every accepted byte, checked against the trailing checksum byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_r     <= 8'd0;
      load_err_r <= 1'b0;
    end else if ((state_r == S_IDLE) || ((state_r == S_DONE) && start)) begin
      csum_r     <= 8'd0;
      load_err_r <= 1'b0;
    end else if (accept_s && (state_r == S_CSUM)) begin
      load_err_r <= (bus.rx_data != csum_r);
    end else if (accept_s) begin
      csum_r <= csum_r ^ bus.rx_data;
    end else begin
      csum_r <= csum_r;
    end
  end

  assign core_hold = (state_r != S_DONE) || load_err_r;
  assign load_err  = load_err_r;
`else
  assign core_hold = (state_r != S_DONE);
  assign load_err  = 1'b0;
`endif

  assign load_done     = (state_r == S_DONE);
  assign bus.rx_ready  = rx_ready_s;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images, random gaps/images and a mid-image reset,
// checked against a word-level model of the expected memory writes.
module tb_imem_loader;
  localparam int          ADDR_W  = 16;
  localparam logic [15:0] START_A = 16'hFFFD;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        rdy;
  } wr_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic core_hold;
  logic load_done;
  logic load_err;

  int n_assert = 0;
  int n_fail   = 0;

  wr_t         obs_q[$];
  logic [31:0] w[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .START_ADDR(START_A)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .start     (start),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Record every memory write seen on the bus.
  always @(negedge clk) begin
    if (rst && bus.mem_we) obs_q.push_back('{bus.mem_addr, bus.mem_wdata, bus.rx_ready});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_core_hold"}, 64'(core_hold), 64'd1);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_load_err"}, 64'(load_err), 64'd0);
  endtask

  // Offer one byte after 'gap' idle cycles; returns on the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int t;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
    t = 0;
    while ((bus.rx_ready !== 1'b1) && (t < 20)) begin
      @(negedge clk);
      t++;
    end
    if (bus.rx_ready !== 1'b1) chk("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic rearm();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rearm_core_hold", 64'(core_hold), 64'd1);
    chk("rearm_load_done", 64'(load_done), 64'd0);
    chk("rearm_load_err", 64'(load_err), 64'd0);
  endtask

  // Stream a whole image and compare the resulting writes with the word list.
  task automatic send_image(input logic [31:0] words[$], input int max_gap, input bit poke,
                            input logic [7:0] csum_flip);
    logic [15:0] n;
    logic [15:0] ea;
    logic [7:0]  b;
    logic [7:0]  x;
    n = 16'(words.size());
    x = n[15:8] ^ n[7:0];
    send_byte(n[15:8], $urandom_range(0, max_gap), poke);
    send_byte(n[7:0], $urandom_range(0, max_gap), poke);
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'(words[i] >> (8 * k));
        x = x ^ b;
        send_byte(b, (k == 3) ? 0 : $urandom_range(0, max_gap), poke);
      end
      chk("we_latency", 64'(bus.mem_we), 64'd1);
      chk("ready_in_write", 64'(bus.rx_ready), 64'd0);
      chk("hold_loading", 64'(core_hold), 64'd1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ csum_flip, $urandom_range(0, max_gap), 1'b0);
    bus.rx_valid = 1'b0;
    chk("csum_done", 64'(load_done), 64'd1);
    chk("csum_hold", 64'(core_hold), 64'(csum_flip != 8'd0));
    chk("csum_err", 64'(load_err), 64'(csum_flip != 8'd0));
`else
    bus.rx_valid = 1'b0;
    if (n != 16'd0) @(negedge clk);
    chk("done_load_done", 64'(load_done), 64'd1);
    chk("done_core_hold", 64'(core_hold), 64'd0);
    chk("done_load_err", 64'(load_err), 64'd0);
`endif
    chk("done_mem_we", 64'(bus.mem_we), 64'd0);
    chk("done_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("wr_count", 64'(obs_q.size()), 64'(words.size()));
    foreach (words[i]) begin
      if (i < obs_q.size()) begin
        ea = START_A + 16'(i);
        chk("wr_addr", 64'(obs_q[i].addr), 64'(ea));
        chk("wr_data", 64'(obs_q[i].data), 64'(words[i]));
        chk("wr_ready", 64'(obs_q[i].rdy), 64'd0);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b1;
    chk("idle_rx_ready", 64'(bus.rx_ready), 64'd0);

    // Basic two-word image, back-to-back bytes
    w = '{32'h12345678, 32'h9ABCDEF0};
    send_image(w, 0, 1'b0, 8'h00);

    // Empty image
    rearm();
    w.delete();
    send_image(w, 0, 1'b0, 8'h00);

    // Same two words with idle gaps and stray start pulses
    rearm();
    w = '{32'h12345678, 32'h9ABCDEF0};
    send_image(w, 3, 1'b1, 8'h00);

    // Reset in the middle of an image
    rearm();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    chk("mid_rst_no_write", 64'(obs_q.size()), 64'd0);
    rst = 1'b1;
    w = '{32'h01020304};
    send_image(w, 1, 1'b0, 8'h00);

    rearm();
    w = '{32'hCAFEBABE};
    send_image(w, 0, 1'b0, 8'h00);

    // Random images, crossing the address wrap
    for (int r = 0; r < 5; r++) begin
      rearm();
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) w.push_back($urandom);
      send_image(w, 2, 1'b1, 8'h00);
    end

`ifdef LOADER_CHECKSUM_EN
    rearm();
    w = '{32'h11223344};
    send_image(w, 0, 1'b0, 8'h00);
    rearm();
    send_image(w, 0, 1'b0, 8'h03);
    rearm();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
